// File: rtl/fc_word_sync_ctrl.sv
// fc_word_sync_ctrl: word-synchronisation controller for the 4-lane 8b10b
// receive path. Runs the acquire / loss-of-sync state machine on decoded
// words, gates data downstream only while in sync, and keeps saturating
// invalid-word and loss-of-sync counters.
// Build option: define FC_WORD_SLIP_EN to enable SerDes bit-slip requests
// while hunting (SLIP state, hunt and hold counters). Without it LOS hunts
// indefinitely and slip_req is tied low.
module fc_word_sync_ctrl #(
    parameter int HUNT_WORDS = 64,
    parameter int SLIP_HOLD  = 16,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_val,
    input  logic [31:0]      in_dat,
    input  logic [3:0]       in_k,
    input  logic [3:0]       in_kerr,
    input  logic [3:0]       in_rderr,
    input  logic             cnt_clr,
    output logic             slip_req,
    output logic             sync,
    output logic [2:0]       state,
    output logic             out_val,
    output logic [31:0]      out_dat,
    output logic [3:0]       out_k,
    output logic [CNT_W-1:0] inv_cnt,
    output logic [CNT_W-1:0] los_cnt
);

    typedef enum logic [2:0] {
        ST_LOS  = 3'd0,
        ST_SLIP = 3'd1,
        ST_ACQ1 = 3'd2,
        ST_ACQ2 = 3'd3,
        ST_SYNC = 3'd4,
        ST_ERR1 = 3'd5,
        ST_ERR2 = 3'd6,
        ST_ERR3 = 3'd7
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_good;
    logic             w_good_nxt;
    logic             w_invalid;
    logic             w_os;
    logic             w_sync;
    logic             w_los_inc;
    logic             w_inv_inc;
    logic             r_out_val;
    logic [31:0]      r_out_dat;
    logic [3:0]       r_out_k;
    logic [CNT_W-1:0] r_inv_cnt;
    logic [CNT_W-1:0] r_los_cnt;

`ifdef FC_WORD_SLIP_EN
    localparam int HUNT_W = $clog2(HUNT_WORDS + 1);
    localparam int HOLD_W = $clog2(SLIP_HOLD + 1);

    logic [HUNT_W-1:0] r_hunt;
    logic [HUNT_W-1:0] w_hunt_nxt;
    logic [HOLD_W-1:0] r_hold;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic              r_slip;
    logic              w_slip_nxt;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^{HUNT_WORDS, SLIP_HOLD};
`endif

    // Word classification: any code or disparity error makes the word invalid;
    // an ordered set must carry K28.5 in byte 0 and no other K characters.
    assign w_invalid = in_val & ((|in_kerr) | (|in_rderr));
    assign w_os      = in_val & ~w_invalid & (in_k == 4'b0001) & (in_dat[7:0] == 8'hBC);

    // The sync group (SYNC, ERR1..ERR3) is exactly the states with the MSB set.
    assign w_sync    = r_state[2];
    assign w_inv_inc = w_invalid & w_sync;

    // Next-state, good-word run and (optionally) hunt/hold/slip decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good;
        w_los_inc   = 1'b0;
`ifdef FC_WORD_SLIP_EN
        w_hunt_nxt  = r_hunt;
        w_hold_nxt  = r_hold;
        w_slip_nxt  = 1'b0;
`endif
        case (r_state)
            ST_LOS: begin
                w_good_nxt = 1'b0;
                if (w_os) begin
                    w_state_nxt = ST_ACQ1;
`ifdef FC_WORD_SLIP_EN
                    w_hunt_nxt  = '0;
                end else if (in_val) begin
                    if (r_hunt == HUNT_W'(HUNT_WORDS - 1)) begin
                        w_slip_nxt  = 1'b1;
                        w_hunt_nxt  = '0;
                        w_hold_nxt  = '0;
                        w_state_nxt = ST_SLIP;
                    end else begin
                        w_hunt_nxt = r_hunt + HUNT_W'(1);
                    end
`endif
                end
            end
            ST_SLIP: begin
`ifdef FC_WORD_SLIP_EN
                // Input is ignored while the SerDes realigns; hold counts clocks.
                if (r_hold == HOLD_W'(SLIP_HOLD - 1)) begin
                    w_hold_nxt  = '0;
                    w_state_nxt = ST_LOS;
                end else begin
                    w_hold_nxt = r_hold + HOLD_W'(1);
                end
`else
                w_state_nxt = ST_LOS;
`endif
            end
            ST_ACQ1: begin
                if (w_os)           w_state_nxt = ST_ACQ2;
                else if (w_invalid) w_state_nxt = ST_LOS;
            end
            ST_ACQ2: begin
                if (w_os)           w_state_nxt = ST_SYNC;
                else if (w_invalid) w_state_nxt = ST_LOS;
            end
            ST_SYNC: begin
                w_good_nxt = 1'b0;
                if (w_invalid) w_state_nxt = ST_ERR1;
            end
            ST_ERR1, ST_ERR2, ST_ERR3: begin
                if (w_invalid) begin
                    w_good_nxt = 1'b0;
                    case (r_state)
                        ST_ERR1: w_state_nxt = ST_ERR2;
                        ST_ERR2: w_state_nxt = ST_ERR3;
                        default: begin
                            w_state_nxt = ST_LOS;
                            w_los_inc   = 1'b1;
                        end
                    endcase
                end else if (in_val) begin
                    // Second consecutive good word steps back one level.
                    if (r_good) begin
                        w_good_nxt = 1'b0;
                        case (r_state)
                            ST_ERR3: w_state_nxt = ST_ERR2;
                            ST_ERR2: w_state_nxt = ST_ERR1;
                            default: w_state_nxt = ST_SYNC;
                        endcase
                    end else begin
                        w_good_nxt = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_LOS;
        endcase
    end

    // FSM state and good-word run register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_LOS;
            r_good  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_good  <= w_good_nxt;
        end
    end

`ifdef FC_WORD_SLIP_EN
    // Hunt/hold counters and the one-cycle slip pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hunt <= '0;
            r_hold <= '0;
            r_slip <= 1'b0;
        end else begin
            r_hunt <= w_hunt_nxt;
            r_hold <= w_hold_nxt;
            r_slip <= w_slip_nxt;
        end
    end

    assign slip_req = r_slip;
`else
    assign slip_req = 1'b0;
`endif

    // One-cycle datapath; valid is qualified by the sync of the current state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_val <= 1'b0;
            r_out_dat <= '0;
            r_out_k   <= '0;
        end else begin
            r_out_val <= in_val & w_sync;
            r_out_dat <= in_dat;
            r_out_k   <= in_k;
        end
    end

    // Saturating invalid-word counter; clear wins over a coincident increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inv_cnt <= '0;
        end else if (cnt_clr) begin
            r_inv_cnt <= '0;
        end else if (w_inv_inc && (r_inv_cnt != {CNT_W{1'b1}})) begin
            r_inv_cnt <= r_inv_cnt + CNT_W'(1);
        end
    end

    // Saturating loss-of-sync counter; clear wins over a coincident increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_los_cnt <= '0;
        end else if (cnt_clr) begin
            r_los_cnt <= '0;
        end else if (w_los_inc && (r_los_cnt != {CNT_W{1'b1}})) begin
            r_los_cnt <= r_los_cnt + CNT_W'(1);
        end
    end

    assign state   = r_state;
    assign sync    = w_sync;
    assign out_val = r_out_val;
    assign out_dat = r_out_dat;
    assign out_k   = r_out_k;
    assign inv_cnt = r_inv_cnt;
    assign los_cnt = r_los_cnt;

endmodule

// File: tb/tb_fc_word_sync_ctrl.sv
// Testbench for fc_word_sync_ctrl: vector table plus hand-written sequences,
// with a scoreboard queue for the gated output words. Counters are built
// 8 bits wide here so saturation is reachable in a short run.
module tb_fc_word_sync_ctrl;

    localparam int CW  = 8;
    localparam int MAX = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          in_val;
    logic [31:0]   in_dat;
    logic [3:0]    in_k;
    logic [3:0]    in_kerr;
    logic [3:0]    in_rderr;
    logic          cnt_clr;
    logic          slip_req;
    logic          sync;
    logic [2:0]    state;
    logic          out_val;
    logic [31:0]   out_dat;
    logic [3:0]    out_k;
    logic [CW-1:0] inv_cnt;
    logic [CW-1:0] los_cnt;

    fc_word_sync_ctrl #(
        .HUNT_WORDS(64),
        .SLIP_HOLD (16),
        .CNT_W     (CW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_val  (in_val),
        .in_dat  (in_dat),
        .in_k    (in_k),
        .in_kerr (in_kerr),
        .in_rderr(in_rderr),
        .cnt_clr (cnt_clr),
        .slip_req(slip_req),
        .sync    (sync),
        .state   (state),
        .out_val (out_val),
        .out_dat (out_dat),
        .out_k   (out_k),
        .inv_cnt (inv_cnt),
        .los_cnt (los_cnt)
    );

    typedef struct {
        logic          val;
        logic [31:0]   dat;
        logic [3:0]    k;
        logic [3:0]    kerr;
        logic [3:0]    rderr;
        logic          clr;
        logic [2:0]    st;
        logic          slip;
        logic [CW-1:0] inv;
        logic [CW-1:0] los;
    } vec_t;

    vec_t        tbl[$];
    vec_t        vtmp;
    logic [35:0] sb_q[$];
    logic [2:0]  exp_state_q;
    int          n_total;
    int          n_bad;
    int          step_no;
    int          e_inv;
    int          e_los;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(int val, int dat, int k, int kerr, int rderr, int clr,
                                int st, int inv, int los);
        vec_t v;
        v.val   = 1'(val);
        v.dat   = 32'(dat);
        v.k     = 4'(k);
        v.kerr  = 4'(kerr);
        v.rderr = 4'(rderr);
        v.clr   = 1'(clr);
        v.st    = 3'(st);
        v.slip  = 1'b0;
        v.inv   = CW'(inv);
        v.los   = CW'(los);
        return v;
    endfunction

    function automatic vec_t os(int n, int st, int inv, int los);
        return mk(1, (n << 8) | 32'hBC, 1, 0, 0, 0, st, inv, los);
    endfunction

    function automatic vec_t dw(int n, int st, int inv, int los);
        return mk(1, (n << 8) | 32'h5A, 0, 0, 0, 0, st, inv, los);
    endfunction

    function automatic vec_t bw(int n, int kerr, int rderr, int st, int inv, int los);
        return mk(1, (n << 8) | 32'h3C, 0, kerr, rderr, 0, st, inv, los);
    endfunction

    function automatic vec_t gp(int st, int inv, int los);
        return mk(0, 32'h0BAD_0000, 0, 0, 0, 0, st, inv, los);
    endfunction

    function automatic int sat(int x);
        return (x > MAX) ? MAX : x;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @step %0d: got %0h want %0h", nm, step_no, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".state"},    64'(state),    64'(0));
        chk({tag, ".sync"},     64'(sync),     64'(0));
        chk({tag, ".slip_req"}, 64'(slip_req), 64'(0));
        chk({tag, ".out_val"},  64'(out_val),  64'(0));
        chk({tag, ".out_dat"},  64'(out_dat),  64'(0));
        chk({tag, ".out_k"},    64'(out_k),    64'(0));
        chk({tag, ".inv_cnt"},  64'(inv_cnt),  64'(0));
        chk({tag, ".los_cnt"},  64'(los_cnt),  64'(0));
    endtask

    // Drive one word at the falling edge, let one rising edge pass, check at the next falling edge.
    task automatic drive_chk(input vec_t v);
        logic        pre_sync;
        logic [35:0] e;
        step_no++;
        pre_sync = (exp_state_q >= 3'd4);
        in_val   = v.val;
        in_dat   = v.dat;
        in_k     = v.k;
        in_kerr  = v.kerr;
        in_rderr = v.rderr;
        cnt_clr  = v.clr;
        if (v.val && pre_sync) sb_q.push_back({v.k, v.dat});
        @(posedge clk);
        @(negedge clk);
        chk("state",    64'(state),    64'(v.st));
        chk("sync",     64'(sync),     64'(v.st >= 3'd4));
        chk("out_val",  64'(out_val),  64'(v.val & pre_sync));
        chk("slip_req", 64'(slip_req), 64'(v.slip));
        chk("inv_cnt",  64'(inv_cnt),  64'(v.inv));
        chk("los_cnt",  64'(los_cnt),  64'(v.los));
        if (out_val) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 64'(1), 64'(0));
            end else begin
                e = sb_q.pop_front();
                chk("out_word", 64'({out_k, out_dat}), 64'(e));
            end
        end
        exp_state_q = v.st;
    endtask

    // Assert reset between clock edges and require every output to clear at once.
    task automatic mid_reset(input string tag);
        #2 rst = 1'b1;
        #1 check_zero({tag, "_async"});
        @(posedge clk);
        @(negedge clk);
        check_zero({tag, "_held"});
        rst = 1'b0;
        exp_state_q = 3'd0;
        sb_q.delete();
        e_inv = 0;
        e_los = 0;
    endtask

    initial begin
        n_total = 0; n_bad = 0; step_no = 0; e_inv = 0; e_los = 0;
        exp_state_q = 3'd0;
        rst = 1'b1; in_val = 1'b0; in_dat = '0; in_k = '0;
        in_kerr = '0; in_rderr = '0; cnt_clr = 1'b0;

        // acquisition with data between ordered sets
        tbl.push_back(os(1, 2, 0, 0));  tbl.push_back(dw(2, 2, 0, 0));
        tbl.push_back(os(3, 3, 0, 0));  tbl.push_back(dw(4, 3, 0, 0));
        tbl.push_back(os(5, 4, 0, 0));  tbl.push_back(dw(6, 4, 0, 0));
        // error ladder up and down
        tbl.push_back(bw(7, 4'b0100, 0, 5, 1, 0));
        tbl.push_back(dw(8, 5, 1, 0));  tbl.push_back(dw(9, 4, 1, 0));
        tbl.push_back(bw(10, 0, 4'b0010, 5, 2, 0));
        tbl.push_back(bw(11, 4'b0100, 0, 6, 3, 0));
        tbl.push_back(dw(12, 6, 3, 0)); tbl.push_back(dw(13, 5, 3, 0));
        // gaps do not break a good-word run
        tbl.push_back(gp(5, 3, 0));     tbl.push_back(dw(14, 5, 3, 0));
        tbl.push_back(gp(5, 3, 0));     tbl.push_back(gp(5, 3, 0));
        tbl.push_back(dw(15, 4, 3, 0)); tbl.push_back(os(16, 4, 3, 0));
        // counter clear on an idle cycle
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 4, 0, 0));
        // four invalid words drop sync
        tbl.push_back(bw(17, 4'b0100, 0, 5, 1, 0));
        tbl.push_back(bw(18, 4'b0100, 0, 6, 2, 0));
        tbl.push_back(bw(19, 4'b0100, 0, 7, 3, 0));
        tbl.push_back(bw(20, 4'b0100, 0, 0, 4, 1));
        // near-miss ordered sets in LOS
        tbl.push_back(mk(1, 32'h0000_BC00, 4'b0010, 0, 0, 0, 0, 4, 1));
        tbl.push_back(mk(1, 32'h0000_00BC, 4'b0001, 4'b0001, 0, 0, 0, 4, 1));
        tbl.push_back(mk(1, 32'h0000_00BC, 4'b0011, 0, 0, 0, 0, 4, 1));
        tbl.push_back(mk(1, 32'h0000_00BD, 4'b0001, 0, 0, 0, 0, 4, 1));
        // acquisition aborted by invalid words
        tbl.push_back(os(21, 2, 4, 1)); tbl.push_back(bw(22, 0, 4'b1000, 0, 4, 1));
        tbl.push_back(os(23, 2, 4, 1)); tbl.push_back(dw(24, 2, 4, 1));
        tbl.push_back(os(25, 3, 4, 1)); tbl.push_back(gp(3, 4, 1));
        tbl.push_back(dw(26, 3, 4, 1)); tbl.push_back(bw(27, 4'b0001, 0, 0, 4, 1));

        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        foreach (tbl[i]) drive_chk(tbl[i]);
        e_inv = 4;
        e_los = 1;

`ifdef FC_WORD_SLIP_EN
        // 64 words without an ordered set produce one slip, then 16 cycles in SLIP
        for (int i = 0; i < 63; i++) drive_chk(dw(100 + i, 0, e_inv, e_los));
        vtmp = dw(200, 1, e_inv, e_los);
        vtmp.slip = 1'b1;
        drive_chk(vtmp);
        for (int i = 0; i < 15; i++) drive_chk(os(300 + i, 1, e_inv, e_los));
        drive_chk(os(400, 0, e_inv, e_los));
        // reset aborts a slip pulse
        for (int i = 0; i < 63; i++) drive_chk(dw(500 + i, 0, e_inv, e_los));
        vtmp = dw(600, 1, e_inv, e_los);
        vtmp.slip = 1'b1;
        drive_chk(vtmp);
        mid_reset("slip_abort");
`else
        for (int i = 0; i < 70; i++) drive_chk(dw(100 + i, 0, e_inv, e_los));
`endif

        // drive both counters into saturation
        for (int i = 0; i < 260; i++) begin
            drive_chk(os(i, 2, e_inv, e_los));
            drive_chk(os(i, 3, e_inv, e_los));
            drive_chk(os(i, 4, e_inv, e_los));
            for (int j = 0; j < 4; j++) begin
                e_inv = sat(e_inv + 1);
                if (j == 3) e_los = sat(e_los + 1);
                drive_chk(bw(i, 4'b0100, 0, (j == 3) ? 0 : 5 + j, e_inv, e_los));
            end
        end
        chk("inv_sat", 64'(inv_cnt), 64'(8'hFF));
        chk("los_sat", 64'(los_cnt), 64'(8'hFF));

        // clear coincident with an invalid word wins
        drive_chk(os(700, 2, MAX, MAX));
        drive_chk(os(701, 3, MAX, MAX));
        drive_chk(os(702, 4, MAX, MAX));
        vtmp = bw(703, 4'b0100, 0, 5, 0, 0);
        vtmp.clr = 1'b1;
        drive_chk(vtmp);
        drive_chk(bw(704, 4'b0100, 0, 6, 1, 0));

        // reset while in ERR2 with in_val toggling
        drive_chk(gp(6, 1, 0));
        drive_chk(dw(705, 6, 1, 0));
        in_val = 1'b1;
        in_kerr = 4'b0100;
        mid_reset("err2");
        drive_chk(os(800, 2, 0, 0));
        drive_chk(os(801, 3, 0, 0));
        drive_chk(dw(802, 3, 0, 0));
        drive_chk(os(803, 4, 0, 0));
        drive_chk(dw(804, 4, 0, 0));

        chk("sb_empty", 64'(sb_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/fc_word_sync_ctrl.md
Name: fc_word_sync_ctrl

Overview:
- Word-synchronisation controller for the 4-lane 8b10b receive path; consumes per-word outputs of the 40b→32b decoder.
- Runs the FC-FS style acquire/loss-of-sync state machine and requests SerDes bit slips while hunting.
- Gates decoded data to downstream framing logic only while in sync, and keeps saturating error and loss-of-sync statistics.

Parameters:
- HUNT_WORDS, 64, valid input words in LOS without a valid ordered set before a slip is issued (≥2).
- SLIP_HOLD, 16, clk cycles held in SLIP after a slip pulse, covering SerDes realignment (≥1).
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  receive word clock.
- rst  in  1  asynchronous reset, active-high.
- in_val  in  1  decoder word valid; the FSM evaluates only when high.
- in_dat  in  32  decoded data; byte 0 at [7:0].
- in_k  in  4  per-byte K flag; bit 0 = byte 0.
- in_kerr  in  4  per-byte code error.
- in_rderr  in  4  per-byte running-disparity error.
- cnt_clr  in  1  synchronous clear of both statistics counters.
- slip_req  out  1  one-cycle bit-slip pulse to the SerDes.
- sync  out  1  high in SYNC, ERR1, ERR2 or ERR3.
- state  out  3  current FSM state encoding.
- out_val  out  1  registered in_val & sync.
- out_dat  out  32  registered in_dat.
- out_k  out  4  registered in_k.
- inv_cnt  out  CNT_W  invalid words seen while sync=1; saturating.
- los_cnt  out  CNT_W  entries into LOS from the sync group; saturating.

Behaviour:
- Reset values: state=LOS(0), sync=0, slip_req=0, out_val=0, out_dat=0, out_k=0, inv_cnt=0, los_cnt=0, hunt counter=0, hold counter=0, good-word counter=0.
- Invalid word: in_val=1 and (|in_kerr | |in_rderr).
- Valid OS: in_val=1, not invalid, in_k=4'b0001 and in_dat[7:0]=8'hBC (K28.5 in byte 0).
- State encoding: LOS=0, SLIP=1, ACQ1=2, ACQ2=3, SYNC=4, ERR1=5, ERR2=6, ERR3=7.
- LOS:
  - Valid OS → ACQ1; clear the hunt counter.
  - Otherwise each in_val word increments the hunt counter.
  - When the count reaches HUNT_WORDS: pulse slip_req for one cycle, clear the counter, go to SLIP.
- SLIP: ignore input; count SLIP_HOLD cycles, then → LOS.
- ACQ1: valid OS → ACQ2; invalid word → LOS; other words hold.
- ACQ2: valid OS → SYNC; invalid word → LOS; other words hold.
- SYNC: invalid word → ERR1.
- ERR1/ERR2/ERR3:
  - An invalid word advances ERR1→ERR2→ERR3; an invalid word in ERR3 → LOS (4th invalid word).
  - Two consecutive non-invalid words step back one level (ERR3→ERR2→ERR1→SYNC).
  - The good-word counter clears on any invalid word and on every step.
- The FSM is frozen while in_val=0; gaps do not break good-word runs.
- Datapath latency is 1 cycle. out_val uses the registered sync of the current state, so the word that causes the SYNC transition is not valid at the output, while the word that causes the LOS transition still is.
- inv_cnt increments on each invalid word while sync=1, including the word that drops sync.
- los_cnt increments on each ERR3→LOS transition.
- Both counters saturate at all-ones. cnt_clr has priority over a coincident increment, so the result is 0.
- Reset asserted mid-operation returns every output to its reset value immediately, including aborting a slip_req pulse.

Optional Feature:
- FC_WORD_SLIP_EN.
- Defined: SLIP state, hunt/hold counters and slip_req behave as above.
- Undefined: slip_req is tied 0, SLIP is unreachable, hunt/hold logic is removed, and LOS hunts indefinitely for a valid OS.

Test Plan:
- Reset, then 3 words {in_k=1, in_dat[7:0]=BC, no errors} with data between them → state 2, 3, 4; sync=1 after the 3rd; out_val=1 from the following word.
- In SYNC, 4 consecutive words with in_kerr=4'b0100 → states 5, 6, 7, 0; los_cnt=1; inv_cnt=4; sync=0.
- In SYNC: invalid, good, good, invalid, invalid, good, good → states 5, 5, 4, 5, 6, 6, 5; los_cnt=0.
- Stream 64 words with no OS, slip enabled → single-cycle slip_req on the 64th; state=1 for 16 cycles, then 0. With FC_WORD_SLIP_EN undefined → slip_req stays 0.
- inv_cnt preloaded to 16'hFFFF by driving invalid words → holds 16'hFFFF; cnt_clr coincident with an invalid word → 0.
- Assert rst while in ERR2 with in_val toggling → all outputs 0 at once; re-acquisition needs 3 fresh valid OS.
